// File: rtl/mult_alu_sequencer_if.sv
// Execute-stage multiply bundle: operand request from the pipeline, borrowed ALU path, HI/LO result.
interface mult_alu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             abort;
    logic [WIDTH-1:0] alu_y;
    logic             alu_grant;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_f;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, sgn, srca, srcb, abort, alu_y,
        input  alu_grant, alu_a, alu_b, alu_f, busy, done, hi, lo
    );

    modport slave (
        input  start, sgn, srca, srcb, abort, alu_y,
        output alu_grant, alu_a, alu_b, alu_f, busy, done, hi, lo
    );
endinterface

// File: rtl/mult_alu_sequencer.sv
// Shift-and-add multiplier that borrows the execute ALU for accumulation and holds HI/LO.
// Start-to-done is WIDTH+3 cycles; busy stalls the pipeline and start is ignored while busy.
module mult_alu_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] ALU_ADD = 3'b010
) (
    input logic                  clk,
    input logic                  rst,
    mult_alu_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] NEG  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             sgnReg;
    logic             negReg;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;

    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH-1:0] iterSum;
    logic             iterCarry;
    logic [PW-1:0]    prodFinal;
    logic             inFlight;

    // The most negative value maps to itself, which is the correct unsigned magnitude.
    assign aMag = (sgnReg && aReg[WIDTH-1]) ? (~aReg + WIDTH'(1)) : aReg;
    assign bMag = (sgnReg && bReg[WIDTH-1]) ? (~bReg + WIDTH'(1)) : bReg;

    // The ALU drops its carry-out; an unsigned wrap below acc recovers it.
    always_comb begin
        iterSum   = acc;
        iterCarry = 1'b0;
        if (mq[0]) begin
            iterSum   = bus.alu_y;
            iterCarry = (bus.alu_y < acc);
        end
    end

    assign prodFinal = negReg ? (~{acc, mq} + PW'(1)) : {acc, mq};
    assign inFlight  = (state == PREP) || (state == ITER) || (state == NEG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            aReg   <= '0;
            bReg   <= '0;
            sgnReg <= 1'b0;
            negReg <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mq     <= '0;
            cnt    <= '0;
            hiReg  <= '0;
            loReg  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.start) begin
                        aReg   <= bus.srca;
                        bReg   <= bus.srcb;
                        sgnReg <= bus.sgn;
                        state  <= PREP;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREP: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        mcand  <= aMag;
                        mq     <= bMag;
                        acc    <= '0;
                        cnt    <= '0;
                        negReg <= sgnReg & (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
                        state  <= ITER;
                    end
                end
                ITER: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        acc <= {iterCarry, iterSum[WIDTH-1:1]};
                        mq  <= {iterSum[0], mq[WIDTH-1:1]};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= NEG;
                        end
                    end
                end
                NEG: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        {acc, mq}      <= prodFinal;
                        {hiReg, loReg} <= prodFinal;
                        state          <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_grant = (state == ITER);
    assign bus.alu_a     = bus.alu_grant ? acc : '0;
    assign bus.alu_b     = bus.alu_grant ? mcand : '0;
    assign bus.alu_f     = ALU_ADD;
    assign bus.busy      = inFlight;
    assign bus.done      = (state == DONE);
    assign bus.hi        = hiReg;
    assign bus.lo        = loReg;
endmodule

// File: tb/tb_mult_alu_sequencer.sv
// Bench for mult_alu_sequencer: vector table plus hand sequences for stall, abort and reset corners.
module tb_mult_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_alu_sequencer_if #(.WIDTH(32)) bus();

    mult_alu_sequencer #(.WIDTH(32), .ALU_ADD(3'b010)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared execute ALU stand-in: adds only when asked for the add function.
    assign bus.alu_y = (bus.alu_f == 3'b010) ? (bus.alu_a + bus.alu_b) : 32'h0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] expQ[$];
    int          passCnt  = 0;
    int          totalCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic popCheck(input string name);
        logic [63:0] e;
        check({name, " done"}, 64'(bus.done), 64'd1);
        if (bus.done !== 1'b1) begin
            expQ.delete();
        end else if (expQ.size() == 0) begin
            check({name, " scoreboard"}, 64'(expQ.size()), 64'd1);
        end else begin
            e = expQ.pop_front();
            check(name, {bus.hi, bus.lo}, e);
        end
    endtask

    task automatic doMul(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, output int cyc, output int busyC, output int grantC);
        bus.sgn   = s;
        bus.srca  = a;
        bus.srcb  = b;
        bus.start = 1'b1;
        expQ.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; busyC = 0; grantC = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy) busyC++;
            if (bus.alu_grant) grantC++;
            @(posedge clk); #1;
            cyc++;
        end
        popCheck(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, bc, gc, dones;
        logic [31:0] ra, rb;

        vecs[0] = '{1'b0, 32'd7,          32'd6,          64'd42};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001};
        vecs[2] = '{1'b1, 32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1};
        vecs[3] = '{1'b1, 32'h80000000,   32'h80000000,   64'h40000000_00000000};
        vecs[4] = '{1'b1, 32'd7,          32'hFFFFFFFA,   64'hFFFFFFFF_FFFFFFD6};
        vecs[5] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'd1};
        vecs[6] = '{1'b0, 32'h80000000,   32'd2,          64'h00000001_00000000};
        vecs[7] = '{1'b0, 32'd0,          32'h12345678,   64'd0};
        vecs[8] = '{1'b1, 32'h80000000,   32'd1,          64'hFFFFFFFF_80000000};
        vecs[9] = '{1'b0, 32'h80000000,   32'h80000000,   64'h40000000_00000000};

        bus.start = 1'b0; bus.sgn = 1'b0; bus.srca = '0; bus.srcb = '0; bus.abort = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",  64'(bus.busy),      64'd0);
        check("reset done",  64'(bus.done),      64'd0);
        check("reset grant", 64'(bus.alu_grant), 64'd0);
        check("reset hilo",  {bus.hi, bus.lo},   64'd0);
        check("reset alu_a", 64'(bus.alu_a),     64'd0);
        check("reset alu_b", 64'(bus.alu_b),     64'd0);
        check("reset alu_f", 64'(bus.alu_f),     64'd2);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            doMul($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p, c, bc, gc);
            if (i == 0) begin
                check("latency",     64'(c),  64'd35);
                check("busy cycles", 64'(bc), 64'd34);
                check("grant cycles",64'(gc), 64'd32);
            end
            @(posedge clk); #1;
            check($sformatf("vec%0d done one cycle", i), 64'(bus.done), 64'd0);
            check($sformatf("vec%0d hilo hold", i), {bus.hi, bus.lo}, vecs[i].p);
        end

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            doMul($sformatf("rand%0d", i), i[0], ra, rb, model(i[0], ra, rb), c, bc, gc);
            @(posedge clk); #1;
        end

        // Second start mid-ITER must be ignored.
        bus.sgn = 1'b0; bus.srca = 32'd7; bus.srcb = 32'd6; bus.start = 1'b1;
        expQ.push_back(64'd42);
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 1;
        while (bus.done !== 1'b1 && c < 100) begin
            bus.start = (c == 10);
            if (c == 10) begin bus.srca = 32'd2; bus.srcb = 32'd2; end
            @(posedge clk); #1;
            c++;
        end
        bus.start = 1'b0;
        check("ignored start latency", 64'(c), 64'd35);
        popCheck("ignored start result");
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("ignored start no extra done", 64'(dones), 64'd0);

        doMul("b2b first", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, c, bc, gc);
        doMul("b2b second", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, c, bc, gc);
        check("b2b latency", 64'(c), 64'd35);
        @(posedge clk); #1;

        // Abort mid-ITER after a 7*6 result.
        doMul("pre-abort", 1'b0, 32'd7, 32'd6, 64'd42, c, bc, gc);
        @(posedge clk); #1;
        bus.srca = 32'd100; bus.srcb = 32'd100; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre-abort grant", 64'(bus.alu_grant), 64'd1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort busy",  64'(bus.busy),      64'd0);
        check("abort done",  64'(bus.done),      64'd0);
        check("abort grant", 64'(bus.alu_grant), 64'd0);
        check("abort hilo",  {bus.hi, bus.lo},   64'd42);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        check("abort hilo hold", {bus.hi, bus.lo}, 64'd42);

        // Abort beats start in IDLE.
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check("abort+start busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset mid-ITER.
        bus.srca = 32'd100; bus.srcb = 32'd100; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async rst busy",  64'(bus.busy),      64'd0);
        check("async rst done",  64'(bus.done),      64'd0);
        check("async rst grant", 64'(bus.alu_grant), 64'd0);
        check("async rst hilo",  {bus.hi, bus.lo},   64'd0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post-rst idle", 64'(bus.busy), 64'd0);
        doMul("post-rst 3*4", 1'b0, 32'd3, 32'd4, 64'd12, c, bc, gc);
        check("post-rst latency", 64'(c), 64'd35);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/mult_alu_sequencer.md
Name: mult_alu_sequencer

Overview:
- Multi-cycle shift-and-add multiply sequencer for the execute stage.
- Borrows the shared execute-stage ALU for accumulation adds while it owns it, stalls the pipeline, and holds the 64-bit HI/LO result.
- Sits between the execute-stage operand muxes (SrcA/SrcB after forwarding), the ALU input muxes, and the hazard unit.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ALU_ADD, 3'b010, ALU function code driven on alu_f for add.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  multiply request (MultStartE); sampled in IDLE or DONE only.
- sgn  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
- srca  input  WIDTH  forwarded operand A; sampled with start.
- srcb  input  WIDTH  forwarded operand B; sampled with start.
- abort  input  1  pipeline flush; cancels an in-flight multiply.
- alu_y  input  WIDTH  shared ALU result.
- alu_grant  output  1  1 = sequencer owns the ALU; the execute mux selects alu_a/alu_b/alu_f.
- alu_a  output  WIDTH  ALU operand A (accumulator).
- alu_b  output  WIDTH  ALU operand B (multiplicand magnitude).
- alu_f  output  3  ALU function; always ALU_ADD.
- busy  output  1  multiply in progress; drives the hazard-unit stall.
- done  output  1  one-cycle pulse when HI/LO are updated.
- hi  output  WIDTH  upper half of the last completed product.
- lo  output  WIDTH  lower half of the last completed product.

Behaviour:
- Reset (rst=0, async): state=IDLE; hi, lo, internal registers, busy, done, alu_grant, alu_a, alu_b all 0; alu_f=ALU_ADD always.
- States: IDLE, PREP, ITER, NEG, DONE.
- IDLE: start=1 captures srca, srcb, sgn; next state PREP.
- PREP (1 cycle): mcand=|a|, acc=0, mq=|b|, cnt=0.
  - Magnitudes are taken only if sgn=1; otherwise the raw operands are used.
  - neg = sgn & (a[MSB] ^ b[MSB]).
  - |0x80000000| = 0x80000000, treated as unsigned.
- ITER (WIDTH cycles, cnt 0..WIDTH-1):
  - Each cycle drives alu_a=acc, alu_b=mcand, alu_grant=1.
  - If mq[0]=1: sum=alu_y, carry=(alu_y < acc, unsigned). Else: sum=acc, carry=0.
  - Register update: acc <= {carry, sum[MSB:1]}; mq <= {sum[0], mq[MSB:1]}.
  - After cnt=WIDTH-1 the next state is NEG.
- NEG (1 cycle): if neg, {acc,mq} <= two's-complement negate of {acc,mq}, using an internal 2*WIDTH incrementer (ALU not used). Next state DONE.
- DONE (1 cycle):
  - hi<=acc and lo<=mq are loaded on the edge entering DONE; done=1 for exactly this cycle.
  - start=1 in DONE begins a new multiply (next state PREP); otherwise next state IDLE.
- busy=1 in PREP, ITER, NEG; 0 in IDLE and DONE.
- alu_grant=1 only in ITER.
- Latency: start accepted at edge T → done=1 during cycle T+WIDTH+3 (35 for WIDTH=32). busy is high for WIDTH+2 cycles.
- start while busy=1 is ignored; no queuing.
- abort=1 in PREP/ITER/NEG: next state IDLE; hi/lo unchanged; no done pulse.
- abort and start in the same IDLE/DONE cycle: abort wins, start is dropped. abort in DONE does not revoke hi/lo already loaded.
- Reset mid-operation clears everything immediately (async). On rst deassertion: IDLE, hi=lo=0.
- hi/lo hold their values indefinitely between completions.

Test Plan:
- Unsigned small: sgn=0, srca=7, srcb=6 → done exactly 35 cycles after start; hi=0, lo=42; busy high for 34 cycles; alu_grant high for 32 cycles.
- Unsigned max: sgn=0, srca=srcb=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 (exercises the carry path).
- Signed mixed: sgn=1, srca=0xFFFFFFFD (-3), srcb=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed min: srca=srcb=0x80000000 → hi=0x40000000, lo=0.
- Start while busy: second start with srca=2, srcb=2 at cycle 10 ignored → first result intact; back-to-back start in the DONE cycle → second done 35 cycles later.
- Abort at ITER cycle 12 after a prior result hi=0, lo=42 → IDLE next cycle; busy=0; no done; hi/lo still 0/42.
- rst=0 pulse mid-ITER → busy, done, alu_grant, hi, lo immediately 0; a fresh 3*4 completes with lo=12.
